// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SEC-DED receiver and the matching encoder.
package hamming_pkg;

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_CORR   = 2'b01;
    localparam logic [1:0] ST_UNCORR = 2'b10;

    // Smallest number of check bits p such that 2^p >= data_w + p + 1.
    function automatic int calc_par_w(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1)
            p = p + 1;
        return p;
    endfunction

    function automatic bit is_pow2(input int i);
        return (i > 0) && ((i & (i - 1)) == 0);
    endfunction

    // Payload bit index carried at Hamming position pos; -1 for check positions.
    function automatic int pos_to_data_idx(input int pos);
        int idx;
        if (is_pow2(pos))
            return -1;
        idx = 0;
        for (int k = 1; k < pos; k++)
            if (!is_pow2(k))
                idx = idx + 1;
        return idx;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome (XOR of set-bit positions) and overall parity of a codeword.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 11,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int N      = DATA_W + PAR_W,
    localparam int CODE_W = N + 1
) (
    input  logic [CODE_W-1:0] code,
    output logic [PAR_W-1:0]  s,
    output logic              g
);

    always_comb begin
        s = '0;
        for (int i = 1; i <= N; i++)
            if (code[i])
                s = s ^ PAR_W'(i);
        g = ^code;
    end

endmodule

// File: rtl/hamming_secded_rx.sv
// Two-stage Hamming SEC-DED decoder with valid/ready backpressure and link-health counters.
module hamming_secded_rx
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 11,
    parameter  int CNT_W  = 5,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int N      = DATA_W + PAR_W,
    localparam int CODE_W = N + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic              s1_valid, s2_valid;
    logic [CODE_W-1:0] s1_code, fixed_code;
    logic [PAR_W-1:0]  s1_s, syn_s;
    logic              s1_g, s1_corr, syn_g;
    logic [DATA_W-1:0] raw_data, fixed_data, dec_data, s2_data;
    logic [1:0]        dec_status, s2_status;
    logic              advance, out_fire;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .code (in_code),
        .s    (syn_s),
        .g    (syn_g)
    );

    // Stage 2 can take a word whenever it is empty or draining; stage 1 then follows it.
    assign advance  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || advance;
    assign out_fire = s2_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_s     <= '0;
            s1_g     <= 1'b0;
            s1_corr  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_s    <= syn_s;
                s1_g    <= syn_g;
                s1_corr <= corr_en;
            end
        end
    end

    // A single error is only trusted when overall parity flags it and s names a real position.
    always_comb begin
        fixed_code = s1_code;
        if (s1_g && (s1_s != '0) && (int'(s1_s) <= N))
            fixed_code[s1_s] = ~s1_code[s1_s];

        raw_data   = '0;
        fixed_data = '0;
        for (int pos = 1; pos <= N; pos++) begin
            if (!is_pow2(pos)) begin
                raw_data[pos_to_data_idx(pos)]   = s1_code[pos];
                fixed_data[pos_to_data_idx(pos)] = fixed_code[pos];
            end
        end

        dec_data   = raw_data;
        dec_status = ST_CLEAN;
        if ((s1_s != '0) || s1_g) begin
            if (!s1_corr) begin
                dec_status = ST_UNCORR;
            end else if (s1_g && (int'(s1_s) <= N)) begin
                dec_status = ST_CORR;
                dec_data   = fixed_data;
            end else begin
                dec_status = ST_UNCORR;
                dec_data   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_status <= ST_CLEAN;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data   <= dec_data;
                s2_status <= dec_status;
            end
        end
    end

    // Counters only see words actually handed to the consumer; a clear overrides an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt <= '0;
            err_cnt  <= '0;
        end else if (cnt_clr) begin
            corr_cnt <= '0;
            err_cnt  <= '0;
        end else if (out_fire) begin
            if ((s2_status == ST_CORR) && (corr_cnt != '1))
                corr_cnt <= corr_cnt + CNT_W'(1);
            if ((s2_status == ST_UNCORR) && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign out_valid  = s2_valid;
    assign out_data   = s2_data;
    assign out_status = s2_status;

endmodule

// File: tb/tb_hamming_secded_rx.sv
// Randomised scoreboard bench for hamming_secded_rx with a positional reference decoder.
module tb_hamming_secded_rx;

    localparam int DATA_W  = 11;
    localparam int CNT_W   = 5;
    localparam int CODE_W  = 16;
    localparam int NPOS    = 15;
    localparam int CNT_MAX = 31;

    logic              clk, rst, in_valid, in_ready, corr_en;
    logic              out_valid, out_ready, cnt_clr;
    logic [CODE_W-1:0] in_code;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic [CNT_W-1:0]  corr_cnt, err_cnt;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        status;
        int                acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks, errors, cyc, mcorr, merr;
    bit   last_acc, exact_lat;

    hamming_secded_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .corr_en    (corr_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_status (out_status),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference decode straight from the codeword rules, using integer bit lists.
    function automatic void refDecode(input logic [15:0] code, input bit corr,
                                      output logic [DATA_W-1:0] data, output logic [1:0] status);
        int bits[16];
        int s, g, dv, k;
        s = 0;
        g = 0;
        for (int i = 0; i < 16; i++) begin
            bits[i] = int'((code >> i) & 16'd1);
            g = g ^ bits[i];
            if (i > 0 && bits[i] == 1)
                s = s ^ i;
        end
        if (s == 0 && g == 0)
            status = 2'b00;
        else if (!corr)
            status = 2'b10;
        else if (g == 1 && s <= NPOS) begin
            status = 2'b01;
            if (s != 0)
                bits[s] = 1 - bits[s];
        end else
            status = 2'b10;
        dv = 0;
        k  = 0;
        for (int pos = 1; pos <= NPOS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                dv = dv | (bits[pos] << k);
                k++;
            end
        end
        data = (corr && status == 2'b10) ? '0 : DATA_W'(dv);
    endfunction

    function automatic logic [15:0] encode(input logic [DATA_W-1:0] d);
        int code_i, s, k, dv;
        code_i = 0;
        s      = 0;
        k      = 0;
        dv     = int'(d);
        for (int pos = 1; pos <= NPOS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (((dv >> k) & 1) == 1) begin
                    code_i = code_i | (1 << pos);
                    s = s ^ pos;
                end
                k++;
            end
        end
        for (int j = 0; j < 4; j++)
            if (((s >> j) & 1) == 1)
                code_i = code_i | (1 << (1 << j));
        if (($countones(code_i) % 2) == 1)
            code_i = code_i | 1;
        return 16'(code_i);
    endfunction

    function automatic logic [15:0] genWord();
        logic [15:0] w;
        int kind, p1, p2;
        w    = encode(DATA_W'($urandom));
        kind = int'($urandom_range(0, 9));
        p1   = int'($urandom_range(0, 15));
        p2   = (p1 + int'($urandom_range(1, 15))) % 16;
        if (kind >= 4 && kind <= 6)
            w = w ^ (16'd1 << p1);
        else if (kind == 7 || kind == 8)
            w = w ^ (16'd1 << p1) ^ (16'd1 << p2);
        else if (kind == 9)
            w = 16'($urandom);
        return w;
    endfunction

    // One clock: observe handshakes at the falling edge, then check counters after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = 1'b0;
        if (in_valid && in_ready) begin
            refDecode(in_code, corr_en, e.data, e.status);
            e.acc = cyc;
            exp_q.push_back(e);
            last_acc = 1'b1;
        end
        if (out_valid) begin
            checkOutput("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                checkOutput("out_data", 32'(out_data), 32'(exp_q[0].data));
                checkOutput("out_status", 32'(out_status), 32'(exp_q[0].status));
                checkOutput("latency_min", 32'(cyc >= exp_q[0].acc + 2), 32'd1);
                if (exact_lat)
                    checkOutput("latency", 32'(cyc - exp_q[0].acc), 32'd2);
                if (out_ready) begin
                    if (exp_q[0].status == 2'b01 && mcorr < CNT_MAX) mcorr++;
                    if (exp_q[0].status == 2'b10 && merr < CNT_MAX) merr++;
                    void'(exp_q.pop_front());
                end
            end
        end
        if (cnt_clr) begin
            mcorr = 0;
            merr  = 0;
        end
        @(posedge clk);
        cyc++;
        #1;
        checkOutput("corr_cnt", 32'(corr_cnt), 32'(mcorr));
        checkOutput("err_cnt", 32'(err_cnt), 32'(merr));
    endtask

    task automatic applyStimulus(input logic [15:0] code, input bit corr);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_code  = code;
        corr_en  = corr;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 100);
        checkOutput("accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0; mcorr = 0; merr = 0;
        last_acc = 1'b0; exact_lat = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_code = '0; corr_en = 1'b1;
        out_ready = 1'b1; cnt_clr = 1'b0;

        #3;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_status", 32'(out_status), 32'd0);
        checkOutput("rst_corr_cnt", 32'(corr_cnt), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] clean words back to back");
        exact_lat = 1'b1;
        applyStimulus(16'h0000, 1'b1);
        applyStimulus(16'hFFFF, 1'b1);
        drain();
        exact_lat = 1'b0;
        checkOutput("t1_corr_cnt", 32'(corr_cnt), 32'd0);
        checkOutput("t1_err_cnt", 32'(err_cnt), 32'd0);

        $display("[TB] single-bit corrections");
        applyStimulus(16'hFFDF, 1'b1);
        applyStimulus(16'h0001, 1'b1);
        drain();
        checkOutput("t2_corr_cnt", 32'(corr_cnt), 32'd2);

        $display("[TB] double error and detect-only mode");
        applyStimulus(16'h0006, 1'b1);
        applyStimulus(16'h0020, 1'b0);
        drain();
        checkOutput("t3_err_cnt", 32'(err_cnt), 32'd2);

        $display("[TB] backpressure stall");
        out_ready = 1'b0;
        applyStimulus(genWord(), 1'b1);
        applyStimulus(genWord(), 1'b1);
        checkOutput("t4_in_ready_low", 32'(in_ready), 32'd0);
        in_code = genWord();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t4_no_accept", 32'(last_acc), 32'd0);
        end
        out_ready = 1'b1;
        applyStimulus(in_code, 1'b1);
        applyStimulus(genWord(), 1'b1);
        drain();

        $display("[TB] error counter saturation and clear");
        for (int i = 0; i < 35; i++)
            applyStimulus(16'h0006, 1'b1);
        drain();
        checkOutput("t5_err_sat", 32'(err_cnt), 32'd31);
        applyStimulus(16'h0006, 1'b1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        checkOutput("t5_out_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checkOutput("t5_err_clr", 32'(err_cnt), 32'd0);

        $display("[TB] reset mid-stall");
        applyStimulus(16'h0001, 1'b1);
        drain();
        checkOutput("t6_corr_pre", 32'(corr_cnt), 32'd1);
        out_ready = 1'b0;
        applyStimulus(16'hFFFF, 1'b1);
        applyStimulus(16'h0000, 1'b1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_out_data", 32'(out_data), 32'd0);
        checkOutput("t6_out_status", 32'(out_status), 32'd0);
        checkOutput("t6_corr_cnt", 32'(corr_cnt), 32'd0);
        checkOutput("t6_err_cnt", 32'(err_cnt), 32'd0);
        exp_q.delete();
        mcorr = 0;
        merr  = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        exact_lat = 1'b1;
        applyStimulus(16'hFFFF, 1'b1);
        drain();
        exact_lat = 1'b0;

        $display("[TB] randomised traffic");
        for (int it = 0; it < 1500; it++) begin
            if (!in_valid || last_acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_code  = genWord();
                    corr_en  = ($urandom_range(0, 4) != 0);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 40) == 0);
            tick();
        end
        cnt_clr = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
